sda_kernel_ctrl: RTL and testbench
==================================

# sda_kernel_ctrl

Kernel control register block on the simple register bus, alongside the kernel argument register block. Decodes a small control and status word window, sequences the kernel start/done handshake through a state machine and counts run cycles. Optionally raises a level interrupt on completion. All read and acknowledge outputs are zero when inactive, so they can be ORed with the other register blocks.

## Interface
Parameters:
- RegAddrWidth, 12, width of regAddr (32-bit word address).
- CtrlAddrBase, 0, word address of CTRL; the block owns words CtrlAddrBase..CtrlAddrBase+5.

Ports:
- clk  in  1  system clock; single clock domain.
- srstn  in  1  reset, synchronous and active-low.
- regReq  in  1  register request; a transaction starts on its rising edge.
- regAck  out  1  one-cycle acknowledge for a decoded access.
- regWriteEn  in  1  1 = write, 0 = read; sampled on the regReq rising edge.
- regAddr  in  RegAddrWidth  word address.
- regWData  in  32  write data.
- regWStrb  in  4  byte strobes; apply to CTRL, GIE and IER only.
- regRData  out  32  read data; valid only while regAck is high, zero otherwise.
- kernGo  out  1  one-cycle start pulse to the kernel.
- kernDone  in  1  one-cycle completion pulse from the kernel.
- argsLock  out  1  high while a run is in progress; argument writes are not permitted by software.
- irq  out  1  level interrupt.

## Operation
Register map (word offset from CtrlAddrBase):
- 0 CTRL:
  - bit0 start: write 1 sets it; self-clears when kernGo issues.
  - bit1 done: read-only, cleared on read.
  - bit2 idle: read-only.
  - bit3 ready: read-only, cleared on read.
  - bit7 autoRestart: read/write.
  - Other bits read 0.
- 1 GIE: bit0 global interrupt enable.
- 2 IER: bit0 done enable, bit1 ready enable.
- 3 ISR: bit0 done, bit1 ready; each bit is set by its event, and writing 1 toggles it.
- 4 CYC_LO: read-only; a read latches the upper half into a snapshot.
- 5 CYC_HI: read-only; returns the snapshot.

State machine:
- IDLE: idle=1. When start=1, go to GO.
- GO: kernGo=1 for exactly one cycle. Clear start, clear the cycle counter, set ready, go to RUN.
- RUN: argsLock=1; the counter increments each cycle and saturates at all-ones. On kernDone, set done and ISR.done, then go to GO if autoRestart=1, otherwise to IDLE.
- kernDone is ignored outside RUN.

Interrupt: irq = GIE & |(IER & ISR).

Boundary and conflict rules:
- A start write while not in IDLE sets the start bit; it is consumed at the next entry to IDLE. With autoRestart=1 it is redundant.
- A clear-on-read of done or ready in the same cycle the corresponding event sets it: the set wins, and the read returns the old value.
- An access outside the 6-word window gets no regAck and regRData stays 0.
- Reset in any state returns to IDLE on the next edge. Any kernDone arriving after reset is ignored.

## Timing
- Reset values: regAck=0, regRData=0, kernGo=0, argsLock=0, irq=0; all registers and the counter 0; state IDLE.
- Access flow:
  - Cycle T: regReq is high and was low in T-1.
  - Cycle T+1: regAck=1 and regRData is valid (decoded accesses only). Register side effects, including clear-on-read, are visible from T+1.
  - regAck lasts one cycle. Back-to-back transactions need regReq to return low for at least one cycle.
- Start latency: a start write at T gives start=1 at T+1, state GO and kernGo=1 at T+2, and RUN at T+3.
- Done latency: kernDone at cycle D gives done=1, ISR set and the state change at D+1, and irq at D+2.
- Cycle count: the number of RUN cycles up to and including the kernDone cycle.

## Configuration
- SDA_KERNEL_CTRL_IRQ_EN defined: GIE, IER and ISR are implemented and irq behaves as above.
- Undefined: words 1–3 still acknowledge, read 0 and ignore writes; irq is tied to 0. The CTRL and counter behaviour is unchanged.

## Structure
- Shared package `sda_kernel_pkg`: register word offsets, CTRL bit positions, and the state encoding (IDLE, GO, RUN).
- Sub-module `sda_reg_edge_decode`: regReq rising-edge detect plus window decode. It outputs a one-cycle access strobe, word index and write flag, and is reusable by the argument register block.

## Test plan
- Reset: drive srstn=0 mid-RUN with kernGo pending → all outputs 0 on the next cycle; a CTRL read afterwards returns 0x4.
- Single run: write CTRL=0x1 at T → kernGo at T+2; kernDone 10 cycles after kernGo → CTRL read returns 0x0E, a second read returns 0x04, CYC_LO=10, CYC_HI=0.
- Auto-restart: write CTRL=0x81, pulse kernDone three times → kernGo pulses four times, each the cycle after RUN is left; clearing autoRestart stops it after the current run.
- IRQ (macro defined): GIE=1, IER=1, run to completion → irq=1 two cycles after kernDone; ISR write 0x1 clears it. With the macro undefined, irq stays 0 and words 1–3 read 0.
- Conflict: kernDone in the same cycle as a CTRL read → the read returns done=0 and a following read returns done=1.
- Decode: read at CtrlAddrBase+6 → no regAck, regRData=0; a write strobe of 0x2 to CTRL with data 0x1 → no start.

Source files
------------

// File: rtl/sda_kernel_pkg.sv
// Shared definitions for the kernel control register block: word offsets,
// CTRL bit positions and the start/done sequencer state encoding.
package sda_kernel_pkg;

    localparam int NumCtrlWords = 6;
    localparam int WordIdxWidth = 3;

    localparam logic [WordIdxWidth-1:0] OffCtrl  = 3'd0;
    localparam logic [WordIdxWidth-1:0] OffGie   = 3'd1;
    localparam logic [WordIdxWidth-1:0] OffIer   = 3'd2;
    localparam logic [WordIdxWidth-1:0] OffIsr   = 3'd3;
    localparam logic [WordIdxWidth-1:0] OffCycLo = 3'd4;
    localparam logic [WordIdxWidth-1:0] OffCycHi = 3'd5;

    localparam int CtrlStartBit       = 0;
    localparam int CtrlDoneBit        = 1;
    localparam int CtrlIdleBit        = 2;
    localparam int CtrlReadyBit       = 3;
    localparam int CtrlAutoRestartBit = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        RUN  = 2'd2
    } kernState_t;

    function automatic logic [31:0] packCtrl(input logic start, input logic done,
                                             input logic idle, input logic ready,
                                             input logic autoRestart);
        logic [31:0] word;
        word = '0;
        word[CtrlStartBit]       = start;
        word[CtrlDoneBit]        = done;
        word[CtrlIdleBit]        = idle;
        word[CtrlReadyBit]       = ready;
        word[CtrlAutoRestartBit] = autoRestart;
        return word;
    endfunction

endpackage

// File: rtl/sda_reg_edge_decode.sv
// Register-bus front end: detects the regReq rising edge and decodes a word
// window, producing a one-cycle access strobe, word index and write flag.
module sda_reg_edge_decode #(
    parameter int RegAddrWidth = 12,
    parameter int WinBase      = 0,
    parameter int WinWords     = 6,
    parameter int IdxWidth     = 3
) (
    input  logic                    clk,
    input  logic                    srstn,
    input  logic                    regReq,
    input  logic                    regWriteEn,
    input  logic [RegAddrWidth-1:0] regAddr,
    output logic                    accessStb,
    output logic                    accessWrite,
    output logic [IdxWidth-1:0]     wordIdx
);

    localparam logic [RegAddrWidth-1:0] BaseAddr = RegAddrWidth'(WinBase);
    localparam logic [RegAddrWidth-1:0] NumWords = RegAddrWidth'(WinWords);

    logic                    regReqQ;
    logic [RegAddrWidth-1:0] offset;
    logic                    inWindow;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            regReqQ <= 1'b0;
        end else begin
            regReqQ <= regReq;
        end
    end

    assign offset      = regAddr - BaseAddr;
    assign inWindow    = (regAddr >= BaseAddr) && (offset < NumWords);
    assign accessStb   = regReq && !regReqQ && inWindow;
    assign accessWrite = regWriteEn;
    assign wordIdx     = offset[IdxWidth-1:0];

endmodule

// File: rtl/sda_kernel_ctrl.sv
// Kernel control/status register block with start/done sequencer and run-cycle
// counter. Define SDA_KERNEL_CTRL_IRQ_EN to implement GIE/IER/ISR and irq.
module sda_kernel_ctrl
    import sda_kernel_pkg::*;
#(
    parameter int RegAddrWidth = 12,
    parameter int CtrlAddrBase = 0
) (
    input  logic                    clk,
    input  logic                    srstn,
    input  logic                    regReq,
    output logic                    regAck,
    input  logic                    regWriteEn,
    input  logic [RegAddrWidth-1:0] regAddr,
    input  logic [31:0]             regWData,
    input  logic [3:0]              regWStrb,
    output logic [31:0]             regRData,
    output logic                    kernGo,
    input  logic                    kernDone,
    output logic                    argsLock,
    output logic                    irq
);

    logic                    accessStb;
    logic                    accessWrite;
    logic [WordIdxWidth-1:0] wordIdx;

    sda_reg_edge_decode #(
        .RegAddrWidth(RegAddrWidth),
        .WinBase     (CtrlAddrBase),
        .WinWords    (NumCtrlWords),
        .IdxWidth    (WordIdxWidth)
    ) uDecode (
        .clk        (clk),
        .srstn      (srstn),
        .regReq     (regReq),
        .regWriteEn (regWriteEn),
        .regAddr    (regAddr),
        .accessStb  (accessStb),
        .accessWrite(accessWrite),
        .wordIdx    (wordIdx)
    );

    kernState_t  state;
    logic        startBit;
    logic        doneBit;
    logic        readyBit;
    logic        autoRestart;
    logic [63:0] cycCount;
    logic [31:0] cycHiSnap;
    logic [31:0] readData;
    logic        isRead;
    logic        isWrite;
    logic        ctrlRead;
    logic        ctrlWrite;
    logic        cycLoRead;
    logic        doneEvent;
    logic        readyEvent;
    logic        unusedBits;

    assign isRead     = accessStb && !accessWrite;
    assign isWrite    = accessStb && accessWrite;
    assign ctrlRead   = isRead && (wordIdx == OffCtrl);
    assign ctrlWrite  = isWrite && (wordIdx == OffCtrl) && regWStrb[0];
    assign cycLoRead  = isRead && (wordIdx == OffCycLo);
    assign doneEvent  = (state == RUN) && kernDone;
    assign readyEvent = (state == GO);

    // Sequencer and CTRL bits. Clear-on-read is applied before the events so
    // a same-cycle set wins; a start write wins over the GO self-clear.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state       <= IDLE;
            kernGo      <= 1'b0;
            argsLock    <= 1'b0;
            startBit    <= 1'b0;
            doneBit     <= 1'b0;
            readyBit    <= 1'b0;
            autoRestart <= 1'b0;
            cycCount    <= '0;
            cycHiSnap   <= '0;
        end else begin
            kernGo <= 1'b0;
            if (ctrlRead) begin
                doneBit  <= 1'b0;
                readyBit <= 1'b0;
            end
            if (cycLoRead) begin
                cycHiSnap <= cycCount[63:32];
            end
            case (state)
                IDLE: begin
                    if (startBit) begin
                        state  <= GO;
                        kernGo <= 1'b1;
                    end
                end
                GO: begin
                    state    <= RUN;
                    argsLock <= 1'b1;
                    startBit <= 1'b0;
                    readyBit <= 1'b1;
                    cycCount <= '0;
                end
                RUN: begin
                    if (cycCount != '1) begin
                        cycCount <= cycCount + 64'd1;
                    end
                    if (kernDone) begin
                        doneBit  <= 1'b1;
                        argsLock <= 1'b0;
                        if (autoRestart) begin
                            state  <= GO;
                            kernGo <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (ctrlWrite) begin
                if (regWData[CtrlStartBit]) begin
                    startBit <= 1'b1;
                end
                autoRestart <= regWData[CtrlAutoRestartBit];
            end
        end
    end

`ifdef SDA_KERNEL_CTRL_IRQ_EN
    logic       gie;
    logic [1:0] ier;
    logic [1:0] isr;
    logic [1:0] isrNext;

    // Software toggles first, then hardware events force their bits set.
    always_comb begin
        isrNext = isr;
        if (isWrite && (wordIdx == OffIsr)) begin
            isrNext = isrNext ^ regWData[1:0];
        end
        isrNext = isrNext | {readyEvent, doneEvent};
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            gie <= 1'b0;
            ier <= '0;
            isr <= '0;
            irq <= 1'b0;
        end else begin
            if (isWrite && (wordIdx == OffGie) && regWStrb[0]) begin
                gie <= regWData[0];
            end
            if (isWrite && (wordIdx == OffIer) && regWStrb[0]) begin
                ier <= regWData[1:0];
            end
            isr <= isrNext;
            irq <= gie && |(ier & isr);
        end
    end

    assign unusedBits = ^{regWData[31:8], regWData[6:2], regWStrb[3:1]};
`else
    assign irq        = 1'b0;
    assign unusedBits = ^{regWData[31:8], regWData[6:1], regWStrb[3:1]};
`endif

    always_comb begin
        readData = '0;
        case (wordIdx)
            OffCtrl:  readData = packCtrl(startBit, doneBit, state == IDLE, readyBit, autoRestart);
`ifdef SDA_KERNEL_CTRL_IRQ_EN
            OffGie:   readData = {31'b0, gie};
            OffIer:   readData = {30'b0, ier};
            OffIsr:   readData = {30'b0, isr};
`endif
            OffCycLo: readData = cycCount[31:0];
            OffCycHi: readData = cycHiSnap;
            default:  readData = '0;
        endcase
    end

    // Bus response stays zero unless acknowledging, so it can be ORed with peers.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            regAck   <= 1'b0;
            regRData <= '0;
        end else begin
            regAck   <= accessStb;
            regRData <= isRead ? readData : '0;
        end
    end

endmodule

// File: tb/tb_sda_kernel_ctrl.sv
// Self-checking bench for sda_kernel_ctrl: table-driven register accesses plus
// hand sequences for runs, auto-restart, conflicts and reset.
module tb_sda_kernel_ctrl;

    localparam int AW = 12;
    localparam logic [AW-1:0] Base = 12'h100;
`ifdef SDA_KERNEL_CTRL_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          srstn;
    logic          regReq;
    logic          regAck;
    logic          regWriteEn;
    logic [AW-1:0] regAddr;
    logic [31:0]   regWData;
    logic [3:0]    regWStrb;
    logic [31:0]   regRData;
    logic          kernGo;
    logic          kernDone;
    logic          argsLock;
    logic          irq;

    int checks   = 0;
    int failures = 0;
    int goCount  = 0;

    typedef struct {
        string       name;
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          expAck;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        string       name;
        bit          expAck;
        logic [31:0] expData;
    } sbEntry_t;

    vec_t     vecs[$];
    sbEntry_t sbQ[$];

    sda_kernel_ctrl #(
        .RegAddrWidth(AW),
        .CtrlAddrBase(256)
    ) dut (
        .clk       (clk),
        .srstn     (srstn),
        .regReq    (regReq),
        .regAck    (regAck),
        .regWriteEn(regWriteEn),
        .regAddr   (regAddr),
        .regWData  (regWData),
        .regWStrb  (regWStrb),
        .regRData  (regRData),
        .kernGo    (kernGo),
        .kernDone  (kernDone),
        .argsLock  (argsLock),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kernGo) goCount++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input bit wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input bit expAck, input logic [31:0] expData);
        vec_t v;
        v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.strb = strb; v.expAck = expAck; v.expData = expData;
        vecs.push_back(v);
    endtask

    // One bus transaction: expectation queued at drive time, compared at T+1,
    // then regReq held low for a cycle so the next call sees a fresh edge.
    task automatic applyStimulus(input string name, input bit wr, input logic [11:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input bit expAck, input logic [31:0] expData,
                                 input bit withDone);
        sbEntry_t e;
        sbEntry_t got;
        e.name = name; e.expAck = expAck; e.expData = expData;
        sbQ.push_back(e);
        regWriteEn = wr; regAddr = addr; regWData = wdata; regWStrb = strb;
        regReq = 1'b1;
        kernDone = withDone;
        @(negedge clk);
        got = sbQ.pop_front();
        checkOutput({got.name, ".ack"}, {31'b0, regAck}, {31'b0, got.expAck});
        checkOutput({got.name, ".rdata"}, regRData, got.expData);
        regReq = 1'b0;
        kernDone = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] expData);
        applyStimulus(name, 1'b0, addr, 32'h0, 4'h0, 1'b1, expData, 1'b0);
    endtask

    task automatic wr(input string name, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
        applyStimulus(name, 1'b1, addr, data, strb, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic pulseDone();
        kernDone = 1'b1;
        @(negedge clk);
        kernDone = 1'b0;
    endtask

    task automatic waitKernGo(input string name);
        int n = 0;
        while (!kernGo && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'b0, kernGo}, 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".regAck"}, {31'b0, regAck}, 32'd0);
        checkOutput({tag, ".regRData"}, regRData, 32'd0);
        checkOutput({tag, ".kernGo"}, {31'b0, kernGo}, 32'd0);
        checkOutput({tag, ".argsLock"}, {31'b0, argsLock}, 32'd0);
        checkOutput({tag, ".irq"}, {31'b0, irq}, 32'd0);
    endtask

    initial begin
        int goStart;
        srstn = 1'b0; regReq = 1'b0; regWriteEn = 1'b0; regAddr = '0;
        regWData = '0; regWStrb = '0; kernDone = 1'b0;
        tick(3);
        checkAllZero("reset");
        srstn = 1'b1;
        tick(1);

        addVec("ctrlReset",   1'b0, Base,          32'h0,  4'h0, 1'b1, 32'h4);
        addVec("cycLoReset",  1'b0, Base + 12'd4,  32'h0,  4'h0, 1'b1, 32'h0);
        addVec("cycHiReset",  1'b0, Base + 12'd5,  32'h0,  4'h0, 1'b1, 32'h0);
        addVec("isrReset",    1'b0, Base + 12'd3,  32'h0,  4'h0, 1'b1, 32'h0);
        addVec("outAbove",    1'b0, Base + 12'd6,  32'h0,  4'h0, 1'b0, 32'h0);
        addVec("outBelow",    1'b0, Base - 12'd1,  32'h0,  4'h0, 1'b0, 32'h0);
        addVec("ctrlWrStrb2", 1'b1, Base,          32'h1,  4'h2, 1'b1, 32'h0);
        addVec("ctrlNoStart", 1'b0, Base,          32'h0,  4'h0, 1'b1, 32'h4);
        addVec("ctrlAutoSet", 1'b1, Base,          32'h80, 4'h1, 1'b1, 32'h0);
        addVec("ctrlAutoRd",  1'b0, Base,          32'h0,  4'h0, 1'b1, 32'h84);
        addVec("ctrlAutoClr", 1'b1, Base,          32'h0,  4'h1, 1'b1, 32'h0);
        addVec("ctrlAutoRd0", 1'b0, Base,          32'h0,  4'h0, 1'b1, 32'h4);
        addVec("outWrite",    1'b1, Base + 12'd6,  32'h1,  4'hF, 1'b0, 32'h0);
        addVec("ctrlAftOut",  1'b0, Base,          32'h0,  4'h0, 1'b1, 32'h4);
        addVec("gieWr",       1'b1, Base + 12'd1,  32'h1,  4'h1, 1'b1, 32'h0);
        addVec("gieRd",       1'b0, Base + 12'd1,  32'h0,  4'h0, 1'b1, IrqEn ? 32'h1 : 32'h0);
        addVec("ierWr3",      1'b1, Base + 12'd2,  32'h3,  4'h1, 1'b1, 32'h0);
        addVec("ierRd3",      1'b0, Base + 12'd2,  32'h0,  4'h0, 1'b1, IrqEn ? 32'h3 : 32'h0);
        addVec("ierWrStrb",   1'b1, Base + 12'd2,  32'h0,  4'h2, 1'b1, 32'h0);
        addVec("ierRdKeep",   1'b0, Base + 12'd2,  32'h0,  4'h0, 1'b1, IrqEn ? 32'h3 : 32'h0);
        addVec("ierWr1",      1'b1, Base + 12'd2,  32'h1,  4'h1, 1'b1, 32'h0);
        addVec("ierRd1",      1'b0, Base + 12'd2,  32'h0,  4'h0, 1'b1, IrqEn ? 32'h1 : 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                          vecs[i].strb, vecs[i].expAck, vecs[i].expData, 1'b0);
        end

        // Single run: kernGo two cycles after the start write, kernDone 10 cycles later.
        wr("runStart", Base, 32'h1, 4'h1);
        checkOutput("runGoT2", {31'b0, kernGo}, 32'd1);
        tick(1);
        checkOutput("runGoOnce", {31'b0, kernGo}, 32'd0);
        checkOutput("runLock", {31'b0, argsLock}, 32'd1);
        tick(9);
        pulseDone();
        checkOutput("runUnlock", {31'b0, argsLock}, 32'd0);
        checkOutput("irqD1", {31'b0, irq}, 32'd0);
        tick(1);
        checkOutput("irqD2", {31'b0, irq}, {31'b0, IrqEn});
        rd("isrAfterRun", Base + 12'd3, IrqEn ? 32'h3 : 32'h0);
        rd("ctrlDone", Base, 32'hE);
        rd("ctrlCleared", Base, 32'h4);
        rd("cycLo", Base + 12'd4, 32'd10);
        rd("cycHi", Base + 12'd5, 32'd0);
        wr("isrToggle", Base + 12'd3, 32'h3, 4'hF);
        checkOutput("irqCleared", {31'b0, irq}, 32'd0);
        rd("isrZero", Base + 12'd3, 32'h0);

        // Pending start during RUN plus a done-vs-read conflict on CTRL.
        wr("confStart", Base, 32'h1, 4'h1);
        waitKernGo("confGo");
        tick(2);
        wr("confPend", Base, 32'h1, 4'h1);
        applyStimulus("confRead", 1'b0, Base, 32'h0, 4'h0, 1'b1, 32'h9, 1'b1);
        checkOutput("pendGo", {31'b0, kernGo}, 32'd1);
        rd("confRead2", Base, 32'h3);
        tick(3);
        pulseDone();
        tick(2);
        rd("readySetWins", Base, 32'hE);
        rd("confClear", Base, 32'h4);

        // Auto-restart: three dones restart, the fourth run stops after clearing.
        goStart = goCount;
        wr("autoStart", Base, 32'h81, 4'h1);
        waitKernGo("autoGo0");
        for (int i = 0; i < 4; i++) begin
            tick(3);
            if (i == 3) wr("autoClr", Base, 32'h0, 4'h1);
            pulseDone();
            checkOutput($sformatf("autoGoAfterDone%0d", i), {31'b0, kernGo},
                        (i < 3) ? 32'd1 : 32'd0);
        end
        tick(3);
        checkOutput("autoGoCount", goCount - goStart, 32'd4);
        rd("autoEndCtrl", Base, 32'hE);
        rd("autoEndCtrl2", Base, 32'h4);

        // Reset mid-run with a pending start, then a stray kernDone.
        wr("rstStart", Base, 32'h81, 4'h1);
        waitKernGo("rstGo");
        tick(2);
        wr("rstPend", Base, 32'h1, 4'h1);
        checkOutput("rstPreLock", {31'b0, argsLock}, 32'd1);
        srstn = 1'b0;
        tick(1);
        checkAllZero("midReset");
        srstn = 1'b1;
        pulseDone();
        tick(3);
        checkOutput("rstNoGo", {31'b0, kernGo}, 32'd0);
        checkOutput("rstNoLock", {31'b0, argsLock}, 32'd0);
        rd("rstCtrl", Base, 32'h4);
        rd("rstCycLo", Base + 12'd4, 32'h0);
        rd("rstGie", Base + 12'd1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
